// File: rtl/aes_axil_ctrl.sv
// aes_axil_ctrl: AXI4-Lite register front-end for a 128-bit AES core.
//
// Ports
//   s00_axi_aclk / s00_axi_areset : clock, synchronous active-high reset
//   s00_axi_aw* / w* / b*         : AXI4-Lite write address, data, response
//   s00_axi_ar* / r*              : AXI4-Lite read address, data
//   aes_key, aes_din              : KEY0-3 / DIN0-3 to the core (word n at [32n+31:32n])
//   aes_start                     : one-cycle start pulse to the core
//   aes_dout, aes_done            : core result and its one-cycle completion pulse
//
// Register map (byte address, addr[1:0] ignored)
//   0x00 CTRL (W bit0 START) | 0x04 STATUS (RO: BUSY, DONE, ERR)
//   0x08 STATUS_CLR (W1C DONE/ERR) | 0x10-0x1C KEY0-3 | 0x20-0x2C DIN0-3
//   0x30-0x3C DOUT0-3 (RO)
module aes_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [127:0]                      aes_key,
  output logic [127:0]                      aes_din,
  output logic                              aes_start,
  input  logic [127:0]                      aes_dout,
  input  logic                              aes_done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state_q, state_d;

  logic [3:0][31:0] key_q;
  logic [3:0][31:0] din_q;
  logic [3:0][31:0] dout_q;
  logic             done_q;
  logic             err_q;
  logic             busy;

  logic             wr_ready_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             rd_ready_q;
  logic             rvalid_q;
  logic [1:0]       rresp_q;
  logic [31:0]      rdata_q;
  logic             start_q;

  logic             wr_hs;
  logic             rd_hs;
  logic [3:0]       wr_idx;
  logic [3:0]       rd_idx;
  logic             wr_hi_bad;
  logic             rd_hi_bad;

  logic             wr_err;
  logic [3:0]       key_we;
  logic [3:0]       din_we;
  logic             start_req;
  logic             clr_done;
  logic             clr_err;

  logic             fire;
  logic             capture;
  logic             start_ignored;

  logic [31:0]      rd_val;
  logic             rd_err;

  logic             unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign busy = (state_q == RUN);

  // One ready register drives both awready and wready so they always
  // pulse together; the write commits on the cycle that ready is high.
  assign s00_axi_awready = wr_ready_q;
  assign s00_axi_wready  = wr_ready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = rd_ready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign aes_start       = start_q;
  assign aes_key         = key_q;
  assign aes_din         = din_q;

  assign wr_hs     = wr_ready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_hs     = rd_ready_q & s00_axi_arvalid;
  assign wr_idx    = s00_axi_awaddr[5:2];
  assign rd_idx    = s00_axi_araddr[5:2];
  assign wr_hi_bad = (s00_axi_awaddr >> 6) != '0;
  assign rd_hi_bad = (s00_axi_araddr >> 6) != '0;

  // Write decode: qualifies every register side effect on the handshake.
  always_comb begin
    wr_err    = 1'b0;
    key_we    = '0;
    din_we    = '0;
    start_req = 1'b0;
    clr_done  = 1'b0;
    clr_err   = 1'b0;
    if (wr_hs) begin
      if (wr_hi_bad) begin
        wr_err = 1'b1;
      end else begin
        case (wr_idx)
          4'h0: start_req = s00_axi_wstrb[0] & s00_axi_wdata[0];
          4'h2: begin
            clr_done = s00_axi_wstrb[0] & s00_axi_wdata[1];
            clr_err  = s00_axi_wstrb[0] & s00_axi_wdata[2];
          end
          4'h4, 4'h5, 4'h6, 4'h7: begin
            if (busy) wr_err = 1'b1;
            else      key_we[wr_idx[1:0]] = 1'b1;
          end
          4'h8, 4'h9, 4'hA, 4'hB: begin
            if (busy) wr_err = 1'b1;
            else      din_we[wr_idx[1:0]] = 1'b1;
          end
          default: wr_err = 1'b1;
        endcase
      end
    end
  end

  // Read mux: sampled into rdata on the read handshake, so a read that
  // coincides with a write commit sees the pre-write contents.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if (rd_hi_bad) begin
      rd_err = 1'b1;
    end else begin
      case (rd_idx)
        4'h0, 4'h2:              rd_val = '0;
        4'h1:                    rd_val = {29'd0, err_q, done_q, busy};
        4'h4, 4'h5, 4'h6, 4'h7:  rd_val = key_q[rd_idx[1:0]];
        4'h8, 4'h9, 4'hA, 4'hB:  rd_val = din_q[rd_idx[1:0]];
        4'hC, 4'hD, 4'hE, 4'hF:  rd_val = dout_q[rd_idx[1:0]];
        default:                 rd_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    fire          = 1'b0;
    capture       = 1'b0;
    start_ignored = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          fire    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (start_req) start_ignored = 1'b1;
        if (aes_done) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rd_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      start_q    <= 1'b0;
      key_q      <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ready_q <= ~wr_ready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      rd_ready_q <= ~rd_ready_q & s00_axi_arvalid & ~rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      start_q <= fire;

      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (key_we[i] && s00_axi_wstrb[b])
            key_q[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
          if (din_we[i] && s00_axi_wstrb[b])
            din_q[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
        end
      end

      if (capture) dout_q <= aes_dout;

      // Completion outranks a coincident W1C so a finished result is never lost.
      if (capture)                done_q <= 1'b1;
      else if (fire || clr_done)  done_q <= 1'b0;

      if (start_ignored)          err_q <= 1'b1;
      else if (clr_err)           err_q <= 1'b0;
    end
  end

endmodule

// File: doc/aes_axil_ctrl.md
AES_AXIL_CTRL -- requirements
Module: aes_axil_ctrl

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, AXI4-Lite byte address width.
REQ-003 SHALL have port s00_axi_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port s00_axi_areset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have AXI4-Lite write ports: s00_axi_awaddr in 6, s00_axi_awprot in 3 (ignored), s00_axi_awvalid in 1, s00_axi_awready out 1, s00_axi_wdata in 32, s00_axi_wstrb in 4, s00_axi_wvalid in 1, s00_axi_wready out 1, s00_axi_bresp out 2, s00_axi_bvalid out 1, s00_axi_bready in 1.
REQ-006 SHALL have AXI4-Lite read ports: s00_axi_araddr in 6, s00_axi_arprot in 3 (ignored), s00_axi_arvalid in 1, s00_axi_arready out 1, s00_axi_rdata out 32, s00_axi_rresp out 2, s00_axi_rvalid out 1, s00_axi_rready in 1.
REQ-007 SHALL have core-side ports: aes_key out 128, aes_din out 128, aes_start out 1 (one-cycle pulse), aes_dout in 128, aes_done in 1 (one-cycle pulse); word n maps to bits [32n+31:32n].

Function
REQ-008 Register map (byte address, addr[1:0] ignored): 0x00 CTRL (W: bit0 START, self-clearing; reads 0); 0x04 STATUS (RO: bit0 BUSY, bit1 DONE, bit2 ERR); 0x08 STATUS_CLR (W1C: bit1 DONE, bit2 ERR; reads 0); 0x10-0x1C KEY0-3 RW; 0x20-0x2C DIN0-3 RW; 0x30-0x3C DOUT0-3 RO; all others unmapped.
REQ-009 Write channel: awready and wready SHALL assert together for exactly one cycle when awvalid and wvalid are both high and bvalid is low; the write commits in that cycle.
REQ-010 bvalid SHALL assert the cycle after the write handshake and hold until bready high; no new write is accepted while bvalid is high.
REQ-011 Read channel: arready SHALL pulse one cycle when arvalid high and rvalid low; rdata/rresp SHALL register the addressed value and rvalid assert the next cycle, held stable until rready high.
REQ-012 RW register writes SHALL honour wstrb per byte; CTRL/STATUS_CLR act only if wstrb[0] set.
REQ-013 bresp/rresp SHALL be 2'b10 (SLVERR) for unmapped addresses, writes to RO registers, and KEY/DIN writes while BUSY; such writes change no state; unmapped reads return 0. Otherwise resp 2'b00.
REQ-014 FSM states IDLE, RUN. IDLE + START write -> aes_start pulses next cycle, BUSY=1, DONE cleared, state RUN.
REQ-015 RUN + aes_done -> DOUT0-3 capture aes_dout, BUSY=0, DONE=1, state IDLE in the same edge.
REQ-016 START written while RUN SHALL be ignored and set ERR=1; no aes_start pulse.
REQ-017 aes_done in IDLE SHALL be ignored (DOUT unchanged, no flag change).
REQ-018 aes_key/aes_din SHALL continuously reflect KEY0-3/DIN0-3, stable throughout RUN.
REQ-019 STATUS_CLR of DONE in the same cycle as aes_done capture: set wins (DONE=1).
REQ-020 Simultaneous read and write handshakes SHALL both proceed; a read of STATUS in the commit cycle returns the pre-write value.

Reset
REQ-021 While s00_axi_areset high at a clock edge: all ready/valid outputs 0, bresp/rresp/rdata 0, aes_start 0, KEY/DIN/DOUT 0, BUSY/DONE/ERR 0, FSM IDLE.
REQ-022 Reset mid-RUN SHALL abort to IDLE; a later aes_done SHALL be ignored; a pending bvalid/rvalid SHALL drop without completing.

Verification
REQ-023 Write KEY0-3=0x00010203..0x0C0D0E0F, DIN0-3=0x11,0x22,0x33,0x44, read back -> identical values, resp OKAY; aes_key[31:0]=0x00010203.
REQ-024 Write CTRL=1 -> aes_start one-cycle pulse, STATUS=0x1; drive aes_done with aes_dout=128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> STATUS=0x2, DOUT0=0x70B4C55A, DOUT3=0x69C4E0D8.
REQ-025 While BUSY: write KEY0=0xFFFFFFFF -> bresp=2'b10, KEY0 unchanged; write CTRL=1 -> no pulse, STATUS=0x5; STATUS_CLR=0x4 -> ERR clears.
REQ-026 Write KEY1 with wstrb=4'b0010, wdata=0xAABBCCDD over 0x00000000 -> KEY1=0x0000CC00; read 0x3C0 region address 0x0C -> rdata 0, rresp 2'b10.
REQ-027 Hold bready low 5 cycles after a write -> bvalid held, awready/wready stay 0 for a queued write; rready low 5 cycles -> rdata stable.
REQ-028 Assert reset during RUN, then pulse aes_done -> STATUS=0, DOUT0-3=0, no spurious bvalid/rvalid.
